// File: rtl/seq_pkg.sv
// Shared types and default sizes for the serial pattern generator.
package seq_pkg;

  // FSM state encoding is visible on state_out, so the values are fixed.
  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StShift  = 2'd1,
    StGap    = 2'd2,
    StParity = 2'd3
  } seq_state_e;

  localparam int unsigned PatWDef = 8;
  localparam int unsigned LenWDef = 4;
  localparam int unsigned RepWDef = 4;
  localparam int unsigned GapWDef = 4;

endpackage

// File: rtl/seq_shift_reg.sv
// Loadable MSB-first shifter. The pattern is left-aligned on load so that
// bit len-1 sits at the MSB; a captured copy allows each repetition to restart.
module seq_shift_reg #(
  parameter int unsigned PAT_W = 8,
  parameter int unsigned LEN_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load_i,
  input  logic             restart_i,
  input  logic             shift_i,
  input  logic [PAT_W-1:0] pat_i,
  input  logic [LEN_W-1:0] len_i,
  output logic             msb_o,
  output logic             next_msb_o,
  output logic             parity_o
);

  logic [PAT_W-1:0] cap_q, cap_d;
  logic [PAT_W-1:0] sr_q, sr_d;
  logic             par_q, par_d;
  logic [LEN_W-1:0] sh_amt;
  logic [PAT_W-1:0] aligned;

  // Align, then load / restart / shift; parity accumulates bits shifted out.
  always_comb begin
    sh_amt  = LEN_W'(PAT_W) - len_i;
    aligned = pat_i << sh_amt;
    cap_d   = cap_q;
    sr_d    = sr_q;
    par_d   = par_q;
    if (load_i) begin
      cap_d = aligned;
      sr_d  = aligned;
      par_d = 1'b0;
    end else if (restart_i) begin
      sr_d  = cap_q;
      par_d = 1'b0;
    end else if (shift_i) begin
      sr_d  = {sr_q[PAT_W-2:0], 1'b0};
      par_d = par_q ^ sr_q[PAT_W-1];
    end
  end

  // Shifter state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cap_q <= '0;
      sr_q  <= '0;
      par_q <= 1'b0;
    end else begin
      cap_q <= cap_d;
      sr_q  <= sr_d;
      par_q <= par_d;
    end
  end

  assign msb_o      = sr_q[PAT_W-1];
  assign next_msb_o = sr_d[PAT_W-1];
  assign parity_o   = par_q;

endmodule

// File: rtl/seq_pattern_gen.sv
// Serial bit-pattern transmitter with repeat count and inter-repetition gap.
// Optional even-parity bit per repetition: define SEQ_PATTERN_GEN_PARITY_EN.
module seq_pattern_gen
  import seq_pkg::*;
#(
  parameter int unsigned PAT_W = PatWDef,
  parameter int unsigned LEN_W = LenWDef,
  parameter int unsigned REP_W = RepWDef,
  parameter int unsigned GAP_W = GapWDef
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             abort,
  input  logic [PAT_W-1:0] pattern_in,
  input  logic [LEN_W-1:0] len_in,
  input  logic [REP_W-1:0] repeat_in,
  input  logic [GAP_W-1:0] gap_in,
  output logic             seq_out,
  output logic             seq_valid,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state_out
);

  seq_state_e       state_q, state_d;
  logic [LEN_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             seq_out_q, seq_out_d;
  logic             seq_valid_q, seq_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [LEN_W-1:0] len_eff;
  logic             load, restart, shift, rep_end, par_sel;
  logic             msb, next_msb, parity, par_bit;

  assign len_eff = (len_in > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : len_in;

  seq_shift_reg #(
    .PAT_W(PAT_W),
    .LEN_W(LEN_W)
  ) u_shift (
    .clk       (clk),
    .reset_n   (reset_n),
    .load_i    (load),
    .restart_i (restart),
    .shift_i   (shift),
    .pat_i     (pattern_in),
    .len_i     (len_eff),
    .msb_o     (msb),
    .next_msb_o(next_msb),
    .parity_o  (parity)
  );

  // Parity over all len bits: bits already shifted out plus the final one.
  assign par_bit = parity ^ msb;

  // Next-state, counter and control decode.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rep_cnt_d   = rep_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    len_d       = len_q;
    gap_d       = gap_q;
    seq_valid_d = 1'b0;
    done_d      = 1'b0;
    load        = 1'b0;
    restart     = 1'b0;
    shift       = 1'b0;
    rep_end     = 1'b0;
    par_sel     = 1'b0;

    case (state_q)
      StIdle: begin
        if (start && (len_in != '0)) begin
          load        = 1'b1;
          state_d     = StShift;
          bit_cnt_d   = len_eff - 1'b1;
          rep_cnt_d   = repeat_in;
          gap_d       = gap_in;
          len_d       = len_eff;
          seq_valid_d = 1'b1;
        end
      end
      StShift: begin
        shift = 1'b1;
        if (bit_cnt_q != '0) begin
          bit_cnt_d   = bit_cnt_q - 1'b1;
          seq_valid_d = 1'b1;
        end else begin
`ifdef SEQ_PATTERN_GEN_PARITY_EN
          state_d     = StParity;
          seq_valid_d = 1'b1;
          par_sel     = 1'b1;
          shift       = 1'b0;
`else
          rep_end     = 1'b1;
`endif
        end
      end
      StGap: begin
        if (gap_cnt_q != '0) begin
          gap_cnt_d = gap_cnt_q - 1'b1;
        end else begin
          restart     = 1'b1;
          state_d     = StShift;
          bit_cnt_d   = len_q - 1'b1;
          seq_valid_d = 1'b1;
        end
      end
`ifdef SEQ_PATTERN_GEN_PARITY_EN
      StParity: begin
        rep_end = 1'b1;
      end
`endif
      default: begin
        state_d = StIdle;
      end
    endcase

    // End of one repetition: gap, immediate restart, or finish.
    if (rep_end) begin
      if (rep_cnt_q != '0) begin
        rep_cnt_d = rep_cnt_q - 1'b1;
        if (gap_q != '0) begin
          state_d   = StGap;
          gap_cnt_d = gap_q - 1'b1;
        end else begin
          restart     = 1'b1;
          shift       = 1'b0;
          state_d     = StShift;
          bit_cnt_d   = len_q - 1'b1;
          seq_valid_d = 1'b1;
        end
      end else begin
        state_d = StIdle;
        done_d  = 1'b1;
      end
    end

    if (abort && (state_q != StIdle)) begin
      state_d     = StIdle;
      seq_valid_d = 1'b0;
      done_d      = 1'b0;
      load        = 1'b0;
      restart     = 1'b0;
      shift       = 1'b0;
      par_sel     = 1'b0;
    end

    busy_d = (state_d != StIdle);
  end

  // Serial data for the next cycle; kept apart so it sees the shifter's next MSB.
  always_comb begin
    seq_out_d = seq_valid_d & (par_sel ? par_bit : next_msb);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      bit_cnt_q   <= '0;
      rep_cnt_q   <= '0;
      gap_cnt_q   <= '0;
      len_q       <= '0;
      gap_q       <= '0;
      seq_out_q   <= 1'b0;
      seq_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rep_cnt_q   <= rep_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      len_q       <= len_d;
      gap_q       <= gap_d;
      seq_out_q   <= seq_out_d;
      seq_valid_q <= seq_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign seq_out   = seq_out_q;
  assign seq_valid = seq_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign state_out = state_q;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Self-checking bench for seq_pattern_gen: directed cases plus random traffic
// compared against a per-transaction expected-cycle queue.
module tb_seq_pattern_gen;

  logic       clk;
  logic       reset_n;
  logic       start;
  logic       abort;
  logic [7:0] pattern_in;
  logic [3:0] len_in;
  logic [3:0] repeat_in;
  logic [3:0] gap_in;
  logic       seq_out;
  logic       seq_valid;
  logic       busy;
  logic       done;
  logic [1:0] state_out;

  int n_vec;
  int n_err;

  typedef struct packed {
    logic       v;
    logic       b;
    logic       bsy;
    logic       dn;
    logic [1:0] st;
  } ent_t;

  ent_t exp_q[$];
  logic cur_idle;

  seq_pattern_gen dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .abort     (abort),
    .pattern_in(pattern_in),
    .len_in    (len_in),
    .repeat_in (repeat_in),
    .gap_in    (gap_in),
    .seq_out   (seq_out),
    .seq_valid (seq_valid),
    .busy      (busy),
    .done      (done),
    .state_out (state_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, got, exp);
    end
  endtask

  // Expected cycles of one accepted transaction, built from the pattern rules.
  task automatic push_txn(input logic [7:0] pat, input logic [3:0] len, input logic [3:0] rep,
                          input logic [3:0] gap);
    int   l;
    logic par;
    l = (len > 8) ? 8 : int'(len);
    for (int r = 0; r <= int'(rep); r++) begin
      par = 1'b0;
      for (int i = l - 1; i >= 0; i--) begin
        exp_q.push_back('{v: 1'b1, b: pat[i], bsy: 1'b1, dn: 1'b0, st: 2'd1});
        par = par ^ pat[i];
      end
`ifdef SEQ_PATTERN_GEN_PARITY_EN
      exp_q.push_back('{v: 1'b1, b: par, bsy: 1'b1, dn: 1'b0, st: 2'd3});
`endif
      if (r < int'(rep)) begin
        for (int g = 0; g < int'(gap); g++) begin
          exp_q.push_back('{v: 1'b0, b: 1'b0, bsy: 1'b1, dn: 1'b0, st: 2'd2});
        end
      end
    end
    exp_q.push_back('{v: 1'b0, b: 1'b0, bsy: 1'b0, dn: 1'b1, st: 2'd0});
  endtask

  // One clock: drive inputs, update the model at the edge, compare after it.
  task automatic step(input logic st, input logic ab, input logic [7:0] pat,
                      input logic [3:0] len, input logic [3:0] rep, input logic [3:0] gap);
    ent_t e;
    start      = st;
    abort      = ab;
    pattern_in = pat;
    len_in     = len;
    repeat_in  = rep;
    gap_in     = gap;
    @(posedge clk);
    if (!cur_idle && ab) exp_q.delete();
    else if (cur_idle && st && (len != 4'd0)) push_txn(pat, len, rep, gap);
    #1;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else e = '{v: 1'b0, b: 1'b0, bsy: 1'b0, dn: 1'b0, st: 2'd0};
    check_eq("seq_out", {7'd0, seq_out}, {7'd0, e.b});
    check_eq("seq_valid", {7'd0, seq_valid}, {7'd0, e.v});
    check_eq("busy", {7'd0, busy}, {7'd0, e.bsy});
    check_eq("done", {7'd0, done}, {7'd0, e.dn});
    check_eq("state_out", {6'd0, state_out}, {6'd0, e.st});
    cur_idle = (e.st == 2'd0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b0, 1'b0, 8'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
    end
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_seq_out"}, {7'd0, seq_out}, 8'd0);
    check_eq({tag, "_seq_valid"}, {7'd0, seq_valid}, 8'd0);
    check_eq({tag, "_busy"}, {7'd0, busy}, 8'd0);
    check_eq({tag, "_done"}, {7'd0, done}, 8'd0);
    check_eq({tag, "_state"}, {6'd0, state_out}, 8'd0);
  endtask

  initial begin
    n_vec      = 0;
    n_err      = 0;
    cur_idle   = 1'b1;
    reset_n    = 1'b0;
    start      = 1'b0;
    abort      = 1'b0;
    pattern_in = '0;
    len_in     = '0;
    repeat_in  = '0;
    gap_in     = '0;
    #12;
    check_zero("reset");
    reset_n = 1'b1;

    // Short pattern 101, single send.
    step(1'b1, 1'b0, 8'b0000_0101, 4'd3, 4'd0, 4'd0);
    idle(5);

    // A5 twice with a two-cycle gap.
    step(1'b1, 1'b0, 8'hA5, 4'd8, 4'd1, 4'd2);
    idle(22);

    // Zero length is ignored; oversize length clamps to 8 bits.
    step(1'b1, 1'b0, 8'hFF, 4'd0, 4'd3, 4'd1);
    idle(3);
    step(1'b1, 1'b0, 8'h96, 4'd12, 4'd0, 4'd0);
    idle(12);

    // Abort early in an 8-bit send, then a fresh full send.
    step(1'b1, 1'b0, 8'hC3, 4'd8, 4'd0, 4'd0);
    step(1'b0, 1'b0, 8'h00, 4'd0, 4'd0, 4'd0);
    step(1'b0, 1'b1, 8'h00, 4'd0, 4'd0, 4'd0);
    idle(2);
    step(1'b1, 1'b0, 8'hC3, 4'd8, 4'd0, 4'd0);
    idle(11);

    // Start held through done: back-to-back sends; mid-send input changes ignored.
    step(1'b1, 1'b0, 8'b110, 4'd3, 4'd0, 4'd0);
    for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 8'b011, 4'd3, 4'd0, 4'd0);
    idle(6);

    // Maximum repeat count, back-to-back repetitions.
    step(1'b1, 1'b0, 8'b10, 4'd2, 4'd15, 4'd0);
    idle(36);

    // Reset in the middle of a send.
    step(1'b1, 1'b0, 8'h5A, 4'd8, 4'd2, 4'd3);
    idle(4);
    reset_n = 1'b0;
    #1;
    check_zero("midreset");
    exp_q.delete();
    cur_idle = 1'b1;
    #2;
    reset_n = 1'b1;
    idle(2);

    // Random traffic.
    for (int i = 0; i < 2000; i++) begin
      step(($urandom_range(0, 3) == 0), ($urandom_range(0, 39) == 0), 8'($urandom),
           4'($urandom), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)));
    end
    idle(80);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
